// File: rtl/servo_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servo_seq_pkg
//  Description : Shared definitions for the servo motion sequencer.
//                - Command header field positions and the header marker.
//                - Parser state encoding.
//                - Channel count.
//                - Bounded slew helper used by the update engine.
//  Revision    : 1.0  initial release
// ============================================================================
package servo_seq_pkg;

    // Number of servo channels driven by the sequencer
    localparam int NUM_CH = 4;

    // Header byte layout
    localparam int HDR_MARK_HI = 7;
    localparam int HDR_MARK_LO = 6;
    localparam int HDR_ALL_BIT = 3;
    localparam int HDR_JUMP_BIT = 2;
    localparam int HDR_CH_HI = 1;
    localparam int HDR_CH_LO = 0;

    // Marker value that identifies a header byte in bits [7:6]
    localparam logic [1:0] HDR_MARKER = 2'b10;

    // Parser states; the encoding is exported on the LED bar
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_APPLY     = 2'd2
    } parser_state_t;

    // Move pos toward tgt by at most step. The difference is formed in
    // 9 bits so it can never wrap, and the move is clamped to the
    // remaining distance so the result never overshoots the target.
    function automatic logic [7:0] slew_step(
        input logic [7:0] pos,
        input logic [7:0] tgt,
        input logic [8:0] step
    );
        logic [8:0] diff;
        logic [8:0] amt;
        logic [7:0] res;
        res  = pos;
        diff = '0;
        amt  = '0;
        if (pos < tgt) begin
            diff = {1'b0, tgt} - {1'b0, pos};
            amt  = (diff > step) ? step : diff;
            res  = pos + amt[7:0];
        end else if (pos > tgt) begin
            diff = {1'b0, pos} - {1'b0, tgt};
            amt  = (diff > step) ? step : diff;
            res  = pos - amt[7:0];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_motion_sequencer_tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Free-running divider producing a single-cycle slew tick.
//                The counter runs 0..TICK_CYCLES-1 and tick_o is high
//                during the cycle in which the count equals TICK_CYCLES-1.
//  Ports       : clk    - system clock
//                rst    - asynchronous active-high reset (count -> 0)
//                tick_o - one-cycle tick strobe
//  Revision    : 1.0  initial release
// ============================================================================
module tick_divider #(
    parameter int TICK_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/servo_motion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : servo_motion_sequencer
//  Description : Parses two-byte motion commands from the UART receiver,
//                holds a target per servo channel and slews each 8-bit
//                position toward its target at a bounded rate. A single
//                update engine visits channels 0..3 in the four clocks
//                following each slew tick.
//  Ports       : clk       - system clock
//                rst       - asynchronous active-high reset
//                rx_data   - received UART byte
//                rx_valid  - one-cycle strobe qualifying rx_data
//                pos_1..4  - current servo positions (registered)
//                moving    - bit i set while channel i is away from target
//                cmd_err   - one-cycle protocol error pulse (registered)
//                led       - {moving, last channel, parser state}
//  Revision    : 1.0  initial release
// ============================================================================
module servo_motion_sequencer
    import servo_seq_pkg::*;
#(
    parameter int         TICK_CYCLES   = 500000,
    parameter int         STEP          = 1,
    parameter logic [7:0] HOME          = 8'd128,
    parameter int         TIMEOUT_TICKS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pos_1,
    output logic [7:0] pos_2,
    output logic [7:0] pos_3,
    output logic [7:0] pos_4,
    output logic [3:0] moving,
    output logic       cmd_err,
    output logic [7:0] led
);

    localparam logic [8:0] STEP_W = 9'(STEP);
    localparam int         TW     = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

    // ------------------------------------------------------------------
    // Slew tick and round-robin scan slots
    // ------------------------------------------------------------------
    logic       tick;
    logic       scan_act_q;
    logic [1:0] slot_q;

    tick_divider #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_divider (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // The four clocks after a tick are scan slots 0..3. TICK_CYCLES >= 8
    // guarantees a scan finishes long before the next tick arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_act_q <= 1'b0;
            slot_q     <= 2'd0;
        end else if (tick) begin
            scan_act_q <= 1'b1;
            slot_q     <= 2'd0;
        end else if (scan_act_q) begin
            slot_q <= slot_q + 2'd1;
            if (slot_q == 2'd3) begin
                scan_act_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command parser
    // ------------------------------------------------------------------
    parser_state_t state_q;
    logic          hdr_all_q;
    logic          hdr_jump_q;
    logic [1:0]    hdr_ch_q;
    logic [7:0]    data_q;
    logic [TW-1:0] tmo_q;
    logic          cmd_err_q;
    logic [1:0]    last_ch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hdr_all_q  <= 1'b0;
            hdr_jump_q <= 1'b0;
            hdr_ch_q   <= 2'd0;
            data_q     <= 8'd0;
            tmo_q      <= '0;
            cmd_err_q  <= 1'b0;
            last_ch_q  <= 2'd0;
        end else begin
            cmd_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tmo_q <= '0;
                    if (rx_valid) begin
                        if (rx_data[HDR_MARK_HI:HDR_MARK_LO] == HDR_MARKER) begin
                            hdr_all_q  <= rx_data[HDR_ALL_BIT];
                            hdr_jump_q <= rx_data[HDR_JUMP_BIT];
                            hdr_ch_q   <= rx_data[HDR_CH_HI:HDR_CH_LO];
                            state_q    <= ST_WAIT_DATA;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    // A data byte arriving on the very tick that would
                    // expire the window still completes the command.
                    if (rx_valid) begin
                        data_q  <= rx_data;
                        state_q <= ST_APPLY;
                    end else if (tick) begin
                        if (tmo_q == TMO_LAST) begin
                            cmd_err_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                ST_APPLY: begin
                    last_ch_q <= hdr_ch_q;
                    // The parser cannot take a byte while applying
                    if (rx_valid) begin
                        cmd_err_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Target and position registers
    // ------------------------------------------------------------------
    logic [7:0] pos_q [NUM_CH];
    logic [7:0] pos_d [NUM_CH];
    logic [7:0] tgt_q [NUM_CH];
    logic [7:0] tgt_d [NUM_CH];
    logic       apply_w;

    assign apply_w = (state_q == ST_APPLY);

    // The slew uses the pre-write target; an APPLY to the same channel in
    // the same cycle overrides the target and, for JUMP, the position too.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            tgt_d[ch] = tgt_q[ch];
            pos_d[ch] = pos_q[ch];
            if (scan_act_q && (slot_q == 2'(ch))) begin
                pos_d[ch] = slew_step(pos_q[ch], tgt_q[ch], STEP_W);
            end
            if (apply_w && (hdr_all_q || (hdr_ch_q == 2'(ch)))) begin
                tgt_d[ch] = data_q;
                if (hdr_jump_q) begin
                    pos_d[ch] = data_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pos_q[ch] <= HOME;
                tgt_q[ch] <= HOME;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pos_q[ch] <= pos_d[ch];
                tgt_q[ch] <= tgt_d[ch];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_moving
        assign moving[g] = (pos_q[g] != tgt_q[g]);
    end

    assign pos_1   = pos_q[0];
    assign pos_2   = pos_q[1];
    assign pos_3   = pos_q[2];
    assign pos_4   = pos_q[3];
    assign cmd_err = cmd_err_q;
    assign led     = {moving, last_ch_q, 2'(state_q)};

endmodule
`default_nettype wire

// File: tb/tb_servo_motion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_motion_sequencer
//  Description : Self-checking bench for servo_motion_sequencer. A
//                behavioural model tracks targets, positions, the parser
//                phase and error pulses from the command rules; every
//                cycle the DUT outputs are compared against it. Directed
//                sequences cover slewing, remainder clamping, JUMP+ALL,
//                protocol errors, timeouts and reset mid-slew, followed by
//                a randomized command stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_servo_motion_sequencer;

    localparam int T     = 8;
    localparam int STEP  = 4;
    localparam int HOME  = 128;
    localparam int TMO   = 3;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_APPLY = 2;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] pos_1, pos_2, pos_3, pos_4;
    logic [3:0] moving;
    logic       cmd_err;
    logic [7:0] led;

    servo_motion_sequencer #(
        .TICK_CYCLES   (T),
        .STEP          (STEP),
        .HOME          (8'(HOME)),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .pos_1    (pos_1),
        .pos_2    (pos_2),
        .pos_3    (pos_3),
        .pos_4    (pos_4),
        .moving   (moving),
        .cmd_err  (cmd_err),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int n_err_seen = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    int         m_pos [4];
    int         m_tgt [4];
    int         m_phase;
    logic [7:0] m_hdr;
    int         m_data;
    int         m_tmo;
    int         m_err;
    int         m_last;
    int         n;        // clocks since reset release

    function automatic int slew(int p, int t);
        if (p < t) return p + (((t - p) < STEP) ? (t - p) : STEP);
        if (p > t) return p - (((p - t) < STEP) ? (p - t) : STEP);
        return p;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_pos[c] = HOME;
            m_tgt[c] = HOME;
        end
        m_phase = P_IDLE;
        m_hdr   = 8'h00;
        m_data  = 0;
        m_tmo   = 0;
        m_err   = 0;
        m_last  = 0;
        n       = 0;
    endtask

    task automatic model_step();
        int  np [4];
        int  nt [4];
        bit  tick;
        tick = ((n % T) == T - 1);
        for (int c = 0; c < 4; c++) begin
            np[c] = m_pos[c];
            nt[c] = m_tgt[c];
        end
        // Channel c is refreshed in the (c+1)-th clock after each tick
        if (n >= T && (n % T) < 4)
            np[n % T] = slew(m_pos[n % T], m_tgt[n % T]);
        m_err = 0;
        if (m_phase == P_IDLE) begin
            if (rx_valid) begin
                if (rx_data[7:6] == 2'b10) begin
                    m_hdr   = rx_data;
                    m_tmo   = 0;
                    m_phase = P_WAIT;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_phase == P_WAIT) begin
            if (rx_valid) begin
                m_data  = int'(rx_data);
                m_phase = P_APPLY;
            end else if (tick) begin
                m_tmo++;
                if (m_tmo >= TMO) begin
                    m_err   = 1;
                    m_phase = P_IDLE;
                end
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (m_hdr[3] || (m_hdr[1:0] == 2'(c))) begin
                    nt[c] = m_data;
                    if (m_hdr[2]) np[c] = m_data;
                end
            end
            m_last = int'(m_hdr[1:0]);
            if (rx_valid) m_err = 1;
            m_phase = P_IDLE;
        end
        for (int c = 0; c < 4; c++) begin
            m_pos[c] = np[c];
            m_tgt[c] = nt[c];
        end
        n++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    function automatic int exp_moving();
        int m;
        m = 0;
        for (int c = 0; c < 4; c++)
            if (m_pos[c] != m_tgt[c]) m = m | (1 << c);
        return m;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pos_1", 32'(pos_1), 32'(m_pos[0]));
            chk("pos_2", 32'(pos_2), 32'(m_pos[1]));
            chk("pos_3", 32'(pos_3), 32'(m_pos[2]));
            chk("pos_4", 32'(pos_4), 32'(m_pos[3]));
            chk("moving", 32'(moving), 32'(exp_moving()));
            chk("cmd_err", 32'(cmd_err), 32'(m_err));
            chk("led", 32'(led), 32'((exp_moving() << 4) | ((m_last & 3) << 2) | (m_phase & 3)));
            if (cmd_err === 1'b1) n_err_seen++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: each put occupies exactly one clock
    // ------------------------------------------------------------------
    task automatic put(input logic v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
    endtask

    task automatic gap(input int k);
        repeat (k) put(1'b0, 8'($urandom));
    endtask

    logic [7:0] b;
    int         r;

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #1;
        chk("rst_pos_1", 32'(pos_1), 32'd128);
        chk("rst_moving", 32'(moving), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Slew on channel index 1 toward 144
        put(1'b1, 8'h81);
        put(1'b1, 8'h90);
        gap(6 * T);
        #1;
        chk("slew_pos_2", 32'(pos_2), 32'd144);
        chk("slew_moving", 32'(moving), 32'd0);

        // Remainder smaller than STEP must land exactly on target
        put(1'b1, 8'h80);
        put(1'b1, 8'd130);
        gap(3 * T);
        #1;
        chk("rem_pos_1", 32'(pos_1), 32'd130);

        // Bad header marker
        put(1'b1, 8'h41);
        put(1'b0, 8'h00);
        #1;
        chk("bad_hdr_err", 32'(cmd_err), 32'd1);
        put(1'b0, 8'h00);
        #1;
        chk("bad_hdr_err_width", 32'(cmd_err), 32'd0);

        // Header with no data byte times out, then a normal command works
        n_err_seen = 0;
        put(1'b1, 8'h80);
        gap((TMO + 1) * T + 4);
        chk("tmo_err_count", 32'(n_err_seen), 32'd1);
        put(1'b1, 8'h82);
        put(1'b1, 8'h50);
        put(1'b0, 8'h00);
        put(1'b0, 8'h00);
        #1;
        chk("after_tmo_moving2", 32'(moving[2]), 32'd1);

        // JUMP + ALL to zero
        put(1'b1, 8'h8C);
        put(1'b1, 8'h00);
        put(1'b0, 8'h00);
        put(1'b0, 8'h00);
        #1;
        chk("jump_all_pos", 32'({pos_1, pos_2, pos_3, pos_4}), 32'd0);
        chk("jump_all_moving", 32'(moving), 32'd0);

        // Reset in the middle of a slew
        put(1'b1, 8'h84);
        put(1'b1, 8'd60);
        put(1'b0, 8'h00);
        put(1'b1, 8'h80);
        put(1'b1, 8'd200);
        gap(3 * T);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_pos_1", 32'(pos_1), 32'd128);
        chk("mid_rst_moving", 32'(moving), 32'd0);
        chk("mid_rst_led", 32'(led), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized command stream
        for (int k = 0; k < 250; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 75) begin
                put(1'b1, {2'b10, 6'($urandom)});
                gap(int'($urandom_range(0, 3)));
                put(1'b1, 8'($urandom));
            end else if (r < 88) begin
                b = 8'($urandom);
                if (b[7:6] == 2'b10) b[7] = 1'b0;
                put(1'b1, b);
            end else begin
                put(1'b1, {2'b10, 6'($urandom)});
                gap(int'($urandom_range(20, 35)));
            end
            gap(int'($urandom_range(0, 12)));
        end
        gap(2 * T);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
